// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction-memory fetch channel between the IF stage and instruction
//   memory. It uses a single-outstanding req/ack handshake.
//
//   req    fetch request, driven by the fetch stage
//   addr   fetch address, held stable while req=1 and ack=0
//   ack    response valid, driven by memory (only meaningful while req=1)
//   rdata  instruction word, valid when ack=1
//
//   master : fetch-stage side
//   slave  : instruction-memory side
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage pipeline. It owns the PC, issues
//   fetches to instruction memory over a req/ack handshake, and loads the
//   IF/ID pipeline register. It honours ID stalls through a one-entry skid
//   buffer and redirects on taken branches from EX. Wrong-path responses
//   that are already in flight are drained and then discarded.
//
//   All state changes on the falling clock edge, like the rest of the
//   pipeline.
//
//   Ports
//     clk           pipeline clock (state updates on negedge)
//     rst_n         asynchronous active-low reset
//     imem          fetch channel to instruction memory (master side)
//     stall         ID stall from the hazard unit; IF/ID holds its value
//     branch_taken  taken branch resolved in EX (redirect + flush)
//     branch_imm16  16-bit word offset of the EX branch
//     branch_pc4    PC+4 of the EX branch
//     if_id_inst    IF/ID instruction register
//     if_id_pc4     IF/ID PC+4 register
//     if_id_valid   IF/ID holds a real instruction
//     pc            address of the next instruction to be requested
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    if_fetch_stage_if.master       imem,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [15:0]            branch_imm16,
    input  logic [31:0]            branch_pc4,
    output logic [31:0]            if_id_inst,
    output logic [31:0]            if_id_pc4,
    output logic                   if_id_valid,
    output logic [31:0]            pc
);

    // FETCH : a request is outstanding on req_addr_reg
    // DROP  : a wrong-path request is outstanding; its response is discarded
    // HOLD  : a fetched instruction waits in the skid buffer while ID stalls
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_reg,     state_next;
    logic [31:0] pc_reg,        pc_next;
    logic [31:0] req_addr_reg,  req_addr_next;
    logic [31:0] inst_reg,      inst_next;
    logic [31:0] pc4_reg,       pc4_next;
    logic        valid_reg,     valid_next;
    logic [31:0] skid_inst_reg, skid_inst_next;
    logic [31:0] skid_pc4_reg,  skid_pc4_next;

    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] req_addr_plus4;

    // Byte offset = sign-extended word offset shifted left by two. The top
    // two bits of the sign extension fall off; the add wraps modulo 2^32.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_offset
            if (gi < 2) begin : g_zero
                assign branch_offset[gi] = 1'b0;
            end else if (gi < 18) begin : g_imm
                assign branch_offset[gi] = branch_imm16[gi-2];
            end else begin : g_sign
                assign branch_offset[gi] = branch_imm16[15];
            end
        end
    endgenerate

    assign branch_target  = branch_pc4 + branch_offset;
    assign req_addr_plus4 = req_addr_reg + 32'd4;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            req_addr_reg  <= RESET_PC;
            inst_reg      <= NOP_INST;
            pc4_reg       <= 32'd0;
            valid_reg     <= 1'b0;
            skid_inst_reg <= 32'd0;
            skid_pc4_reg  <= 32'd0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            req_addr_reg  <= req_addr_next;
            inst_reg      <= inst_next;
            pc4_reg       <= pc4_next;
            valid_reg     <= valid_next;
            skid_inst_reg <= skid_inst_next;
            skid_pc4_reg  <= skid_pc4_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        req_addr_next  = req_addr_reg;
        inst_next      = inst_reg;
        pc4_next       = pc4_reg;
        valid_next     = valid_reg;
        skid_inst_next = skid_inst_reg;
        skid_pc4_next  = skid_pc4_reg;

        case (state_reg)
            ST_FETCH: begin
                if (imem.ack) begin
                    if (branch_taken) begin
                        // Response is wrong-path; restart at the target.
                        pc_next       = branch_target;
                        req_addr_next = branch_target;
                    end else if (!stall) begin
                        inst_next     = imem.rdata;
                        pc4_next      = req_addr_plus4;
                        valid_next    = 1'b1;
                        pc_next       = req_addr_plus4;
                        req_addr_next = req_addr_plus4;
                    end else begin
                        // ID cannot accept it yet: park it and pause fetching.
                        skid_inst_next = imem.rdata;
                        skid_pc4_next  = req_addr_plus4;
                        pc_next        = req_addr_plus4;
                        state_next     = ST_HOLD;
                    end
                end else begin
                    if (branch_taken) begin
                        // The address must stay stable until the old request
                        // is acked, so drain it in DROP.
                        pc_next    = branch_target;
                        state_next = ST_DROP;
                    end else if (!stall) begin
                        inst_next  = NOP_INST;
                        valid_next = 1'b0;
                    end
                end
            end

            ST_DROP: begin
                if (branch_taken) begin
                    pc_next = branch_target;
                end
                if (imem.ack) begin
                    // The next request starts at the latest redirect target.
                    req_addr_next = branch_taken ? branch_target : pc_reg;
                    state_next    = ST_FETCH;
                end
                if (!stall) begin
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    // The buffered instruction is wrong-path.
                    pc_next       = branch_target;
                    req_addr_next = branch_target;
                    state_next    = ST_FETCH;
                end else if (!stall) begin
                    inst_next     = skid_inst_reg;
                    pc4_next      = skid_pc4_reg;
                    valid_next    = 1'b1;
                    req_addr_next = pc_reg;
                    state_next    = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // A taken branch flushes IF/ID even while ID is stalled.
        if (branch_taken) begin
            inst_next  = NOP_INST;
            valid_next = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign imem.req    = rst_n && ((state_reg == ST_FETCH) || (state_reg == ST_DROP));
    assign imem.addr   = req_addr_reg;
    assign if_id_inst  = inst_reg;
    assign if_id_pc4   = pc4_reg;
    assign if_id_valid = valid_reg;
    assign pc          = pc_reg;

    // The fetch address must not move while a request waits for its ack.
    addr_stable_while_waiting: assert property (
        @(negedge clk) disable iff (!rst_n)
        (imem.req && !imem.ack) |=> $stable(imem.addr)
    );

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the ID stage of the 5-stage pipelined CPU.
- Owns the PC and sends fetch requests to instruction memory over a req/ack handshake.
- Produces the IF/ID pipeline register (instruction, PC+4, valid) consumed by decode.
- Accepts stalls from the hazard unit and taken-branch redirects from EX, and drops any wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
NOP_INST, 32'h0000_0000, value loaded into if_id_inst on bubble or flush (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock; all state updates on negedge clk, matching the rest of the pipeline
rst_n  input  1  reset; asynchronous, active-low
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; held stable while imem_req=1 and imem_ack=0
imem_ack  input  1  instruction memory response valid; ignored when imem_req=0
imem_rdata  input  32  instruction word; valid when imem_ack=1
stall  input  1  ID stall from hazard unit; IF/ID register must hold
branch_taken  input  1  taken branch resolved in EX (nPC_sel)
branch_imm16  input  16  branch offset of the EX instruction
branch_pc4  input  32  PC+4 of the EX branch instruction
if_id_inst  output  32  IF/ID instruction register
if_id_pc4  output  32  IF/ID PC+4 register
if_id_valid  output  1  IF/ID holds a real instruction
pc  output  32  address of the next instruction to fetch

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, req_addr=RESET_PC, state=FETCH, if_id_inst=NOP_INST, if_id_pc4=0, if_id_valid=0, skid buffer cleared, imem_req=0.
- imem_req = rst_n && (state==FETCH || state==DROP).
- imem_addr = req_addr. req_addr loads from pc only when a new request starts.
- Branch target = branch_pc4 + {sext(branch_imm16)[29:0],2'b00}, computed modulo 2^32 (wraps; no overflow flag).
- Flush has priority over stall: branch_taken=1 at a clock edge forces if_id_inst=NOP_INST and if_id_valid=0, even when stall=1.
- States:
  - FETCH, ack=1:
    - branch_taken: discard rdata; pc=req_addr=target; stay in FETCH.
    - stall=0: IF/ID <= {rdata, req_addr+4, 1}; pc=req_addr=req_addr+4; stay in FETCH. This gives 1 instruction per cycle on zero-wait memory.
    - stall=1: skid buffer <= {rdata, req_addr+4}; pc=req_addr+4; IF/ID holds; go to HOLD.
  - FETCH, ack=0:
    - branch_taken: pc=target; go to DROP. The request stays asserted with the old address.
    - Otherwise: if stall=0, IF/ID <= bubble (valid=0); if stall=1, IF/ID holds.
  - DROP: imem_req=1 on the stale address.
    - On ack: discard rdata; req_addr=pc; go to FETCH.
    - A further branch_taken in DROP updates pc to the new target.
    - IF/ID gets a bubble unless stall=1, except that flush still applies.
  - HOLD: imem_req=0.
    - branch_taken: discard the buffer; pc=req_addr=target; go to FETCH.
    - Else if stall=0: IF/ID <= {buffer, valid=1}; req_addr=pc; go to FETCH.
    - Else remain in HOLD.
- Latency: an instruction acked at edge n appears on if_id_* after edge n. Wrong-path instructions never reach IF/ID with valid=1.
- pc always equals the next address to be requested.
- Reset asserted mid-request returns to the reset state immediately. Any ack arriving while rst_n=0 is ignored.

Test Plan:
- Reset release, RESET_PC=0, ack every cycle, rdata=addr^32'hA5A5_0000: if_id_pc4 steps 4,8,12; if_id_valid=1 from the first edge with an ack; imem_addr steps 0,4,8.
- Ack delayed 2 cycles per request: imem_addr held stable 3 cycles per request; if_id_valid=0 for 2 cycles, then 1 for one cycle; no address skipped.
- stall=1 in the same cycle as an ack at addr 0x10: state goes to HOLD and imem_req=0; IF/ID keeps its previous value; on stall=0, if_id_inst=rdata@0x10 and if_id_pc4=0x14; next imem_addr=0x14.
- branch_taken with branch_pc4=0x20, imm16=16'h0003 while a fetch to 0x40 waits: the 0x40 response is discarded in DROP; next imem_addr=0x2C; IF/ID valid=0 until 0x2C returns.
- branch_taken while stall=1 and in HOLD: if_id_inst=NOP_INST, if_id_valid=0, buffer dropped, next request is the target.
- branch_pc4=0x4, imm16=16'hFFFE: target=32'hFFFF_FFFC (wrap); pc=32'hFFFF_FFFC.
